fc_sequencer: RTL and testbench
===============================

# fc_sequencer

Controller that sequences one classification pass through the fully connected output layer. It fetches a 64-byte feature vector from the upstream feature buffer as 16 beats of 4 signed bytes and streams them to the FC datapath on contiguous cycles while holding its enable. It then waits for the FC completion flag, captures the 2-bit class, and presents it downstream on a valid/ready handshake. It sits between the last pooling stage's feature buffer and the classification output / host status logic.

## Interface
- TIMEOUT_CYCLES, default 8, max cycles spent in WAIT for fc_flag before abort (used only with FC_TIMEOUT_EN)
- BEATS, default 16, number of 4-byte beats per vector; fixed to match the FC layer
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse: feature vector is complete in the buffer
- abort  in  1  synchronous abort; returns to IDLE from any state
- mem_rd_en  out  1  feature buffer read strobe; data returns 1 cycle later
- mem_addr  out  4  beat index 0..15
- mem_rd_data  in  32  4 x int8, byte 0 in bits [7:0]
- fc_en  out  1  FC enable; low clears FC accumulators
- fc_in  out  4x8 signed  beat to FC; combinational passthrough of mem_rd_data
- fc_flag  in  1  FC done
- fc_class  in  2  FC result, valid while fc_flag=1
- out_valid  out  1  class result valid
- out_ready  in  1  downstream accepts
- out_class  out  2  captured class (0 = normal)
- busy  out  1  high in every state except IDLE
- err  out  1  sticky timeout error (FC_TIMEOUT_EN only; otherwise tied 0)

## Operation
- States: IDLE, PREFETCH, STREAM, WAIT, OUT.
- IDLE: fc_en=0, mem_rd_en=0. On start, go to PREFETCH.
- PREFETCH: mem_rd_en=1, mem_addr=0. Go to STREAM; beat counter=0.
- STREAM: fc_en=1; fc_in = mem_rd_data for beat k. While k<15, mem_rd_en=1 and mem_addr=k+1. At k=15, go to WAIT. Beats must be contiguous; there is no stall.
- WAIT: fc_en remains 1; mem_rd_en=0. When fc_flag=1, register fc_class into out_class and go to OUT.
- OUT: fc_en=0, so the FC accumulators clear; out_valid=1. On out_valid & out_ready, go to IDLE.
- start is ignored when the state is not IDLE; it is not queued.
- abort: return to IDLE next edge, with fc_en=0, out_valid=0 and no result. Abort has priority over all other transitions, including a same-cycle out_ready.
- out_class is stable while out_valid=1 and is only updated in WAIT.
- fc_en is low for at least one cycle between passes (OUT and IDLE), which guarantees the FC accumulator clear.

## Timing
- Reset values: state=IDLE, mem_rd_en=0, mem_addr=0, fc_en=0, out_valid=0, out_class=0, busy=0, err=0.
- start sampled at edge 0; PREFETCH in cycle 1; STREAM in cycles 2..17 (16 cycles with fc_en=1).
- fc_flag is expected in cycle 18, where WAIT captures the class.
- out_valid rises in cycle 19. Latency from start to out_valid is 19 cycles.
- Minimum pass period is 20 cycles with out_ready tied high.
- mem_addr and mem_rd_en are registered outputs. fc_in has a zero-cycle path from mem_rd_data.

## Configuration
- FC_TIMEOUT_EN defined:
  - A WAIT-cycle counter runs.
  - If fc_flag is not seen within TIMEOUT_CYCLES WAIT cycles, set err (sticky until rst_n) and go to IDLE with fc_en=0 and no out_valid.
- FC_TIMEOUT_EN undefined:
  - WAIT waits indefinitely.
  - err is constant 0.
  - No counter logic is generated.

## Structure
- Package fc_seq_pkg holds:
  - the state enum fc_seq_state_t;
  - the constants FC_BEATS=16 and FC_BEAT_W=32;
  - the class encoding CLASS_NORMAL=0 / CLASS_ABNORMAL=1.
- Single module with no sub-module. The beat counter and the WAIT timeout counter are inline.

## Test plan
- Reset sequence: buffer loaded with the FC weight-matching pattern, start pulse, then the FC model's fc_flag:
  - mem_addr runs 0..15 on cycles 1..16, and fc_en is high exactly on cycles 2..18;
  - out_valid rises in cycle 19 with out_class equal to the model's class.
- Backpressure: out_ready held low for 10 cycles. out_valid and out_class are held constant, then drop one cycle after out_ready=1.
- start issued in cycles 5 and 18 of an active pass: both are ignored, and exactly one result is produced.
- abort in STREAM beat 7: state is IDLE next cycle, fc_en=0, no out_valid; a following start yields a correct full pass.
- With FC_TIMEOUT_EN and TIMEOUT_CYCLES=8, fc_flag held low: err=1 and busy=0 eight WAIT cycles after beat 15; err persists across the next pass.
- Back-to-back passes with out_ready=1 and start issued in IDLE: 20-cycle period, fc_en low for at least 1 cycle between passes, with normal then abnormal classes reported in order.

Source files
------------

// File: rtl/fc_seq_pkg.sv
// Shared types and constants for the FC-layer sequencer.
//   fc_seq_state_t : sequencer FSM state encoding
//   FC_BEATS       : 4-byte beats per feature vector
//   FC_BEAT_W      : width of one feature-buffer beat
//   CLASS_*        : class encoding reported downstream
package fc_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrefetch,
    StStream,
    StWait,
    StOut
  } fc_seq_state_t;

  localparam int unsigned FC_BEATS  = 16;
  localparam int unsigned FC_BEAT_W = 32;

  localparam logic [1:0] CLASS_NORMAL   = 2'd0;
  localparam logic [1:0] CLASS_ABNORMAL = 2'd1;

endpackage

// File: rtl/fc_sequencer.sv
// Sequences one classification pass through the fully connected output layer:
// fetches a 16-beat feature vector, streams it to the FC datapath on contiguous
// cycles, waits for the FC done flag, then offers the class on valid/ready.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle request, honoured only in IDLE
//   abort                synchronous return to IDLE from any state
//   mem_rd_en, mem_addr  registered feature-buffer read (data one cycle later)
//   mem_rd_data          4 x int8 beat, byte 0 in [7:0]
//   fc_en, fc_in         FC enable (low clears accumulators) and beat passthrough
//   fc_flag, fc_class    FC completion and result
//   out_valid/ready/class  downstream result handshake
//   busy                 high whenever not IDLE
//   err                  sticky WAIT timeout
//
// Build option: define FC_TIMEOUT_EN to bound WAIT to TIMEOUT_CYCLES cycles.
// Without it WAIT is unbounded and err is tied low.
module fc_sequencer
  import fc_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter int unsigned BEATS          = FC_BEATS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   mem_rd_en,
  output logic [3:0]             mem_addr,
  input  logic [FC_BEAT_W-1:0]   mem_rd_data,
  output logic                   fc_en,
  output logic signed [3:0][7:0] fc_in,
  input  logic                   fc_flag,
  input  logic [1:0]             fc_class,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_class,
  output logic                   busy,
  output logic                   err
);

  localparam logic [3:0] LastBeat = 4'(BEATS - 1);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  fc_seq_state_t state_q, state_d;
  logic [3:0]    beat_q, beat_d;
  logic          mem_rd_en_q, mem_rd_en_d;
  logic [3:0]    mem_addr_q, mem_addr_d;
  logic [1:0]    class_q, class_d;
  logic          timeout;

`ifdef FC_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  // Counts cycles spent in WAIT; cleared whenever the FSM is elsewhere.
  assign wait_cnt_d = (state_q == StWait) ? wait_cnt_q + WaitW'(1) : '0;
  assign timeout    = (state_q == StWait) && !fc_flag &&
                      (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1));
  assign err_d      = err_q | timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    class_d = class_q;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StPrefetch;
      end
      StPrefetch: begin
        state_d = StStream;
        beat_d  = '0;
      end
      StStream: begin
        if (beat_q == LastBeat) state_d = StWait;
        else                    beat_d  = beat_q + 4'd1;
      end
      StWait: begin
        if (fc_flag) begin
          class_d = fc_class;
          state_d = StOut;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything and must not leave a fresh class behind.
    if (abort) begin
      state_d = StIdle;
      class_d = class_q;
    end

    // Read strobe/address are registered, so derive them from the next state:
    // the address issued alongside beat k is k+1 (data lands one cycle later).
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    if (state_d == StPrefetch) begin
      mem_rd_en_d = 1'b1;
      mem_addr_d  = '0;
    end else if ((state_d == StStream) && (beat_d != LastBeat)) begin
      mem_rd_en_d = 1'b1;
      mem_addr_d  = beat_d + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      class_q     <= CLASS_NORMAL;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      class_q     <= class_d;
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign fc_in     = mem_rd_data;
  // fc_en drops in OUT and IDLE, giving the FC at least one clear cycle per pass.
  assign fc_en     = (state_q == StStream) || (state_q == StWait);
  assign out_valid = (state_q == StOut);
  assign out_class = class_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fc_sequencer.sv
// Directed bench for fc_sequencer. Cycle c of a pass is the cycle after the
// edge that samples start (c=1 is PREFETCH). Inputs are driven and outputs
// sampled 1 time unit after each rising edge.
module tb_fc_sequencer;
  import fc_seq_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic                   mem_rd_en;
  logic [3:0]             mem_addr;
  logic [31:0]            mem_rd_data;
  logic                   fc_en;
  logic signed [3:0][7:0] fc_in;
  logic                   fc_flag = 1'b0;
  logic [1:0]             fc_class = 2'd0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [1:0]             out_class;
  logic                   busy;
  logic                   err;

  logic [31:0] mem [16];
  int total = 0;
  int bad   = 0;

  fc_sequencer #(
    .TIMEOUT_CYCLES(8),
    .BEATS         (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .fc_en      (fc_en),
    .fc_in      (fc_in),
    .fc_flag    (fc_flag),
    .fc_class   (fc_class),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Feature buffer: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    start = 1'b1;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
    total++; if (mem_addr !== 4'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
    total++; if (fc_en !== 1'b0) begin bad++; $display("FAIL reset_fc_en: got %b want 0", fc_en); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_class !== 2'd0) begin bad++; $display("FAIL reset_class: got %0d want 0", out_class); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_after: got %b want 0", busy); end
  endtask

  task automatic test_full_pass();
    logic exp_b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      exp_b = (c <= 16);
      total++; if (mem_rd_en !== exp_b) begin bad++; $display("FAIL pass_rd_en c=%0d: got %b want %b", c, mem_rd_en, exp_b); end
      if (c <= 16) begin
        total++; if (mem_addr !== 4'(c - 1)) begin bad++; $display("FAIL pass_addr c=%0d: got %0d want %0d", c, mem_addr, c - 1); end
      end
      exp_b = (c >= 2);
      total++; if (fc_en !== exp_b) begin bad++; $display("FAIL pass_fc_en c=%0d: got %b want %b", c, fc_en, exp_b); end
      if (c >= 2 && c <= 17) begin
        total++; if (fc_in !== mem[c-2]) begin bad++; $display("FAIL pass_fc_in c=%0d: got %h want %h", c, fc_in, mem[c-2]); end
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pass_early_valid c=%0d: got %b want 0", c, out_valid); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL pass_busy c=%0d: got %b want 1", c, busy); end
      if (c == 18) begin
        fc_flag  = 1'b1;
        fc_class = CLASS_ABNORMAL;
      end
      tick();
    end
    fc_flag  = 1'b0;
    fc_class = 2'd0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pass_valid19: got %b want 1", out_valid); end
    total++; if (out_class !== CLASS_ABNORMAL) begin bad++; $display("FAIL pass_class: got %0d want 1", out_class); end
    total++; if (fc_en !== 1'b0) begin bad++; $display("FAIL pass_fc_en19: got %b want 0", fc_en); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pass_valid20: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pass_busy20: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    fc_flag  = 1'b1;
    fc_class = 2'd2;
    tick();
    fc_flag  = 1'b0;
    fc_class = 2'd0;
    for (int i = 0; i < 10; i++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid i=%0d: got %b want 1", i, out_valid); end
      total++; if (out_class !== 2'd2) begin bad++; $display("FAIL bp_class i=%0d: got %0d want 2", i, out_class); end
      tick();
    end
    out_ready = 1'b1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_at_ready: got %b want 1", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_start_ignored();
    int n_valid = 0;
    int v_cyc   = 0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 25; c++) begin
      start    = (c == 5) || (c == 18);
      fc_flag  = (c == 18);
      fc_class = 2'd3;
      if (out_valid) begin
        n_valid++;
        v_cyc = c;
      end
      tick();
    end
    start   = 1'b0;
    fc_flag = 1'b0;
    total++; if (n_valid !== 1) begin bad++; $display("FAIL ign_count: got %0d want 1", n_valid); end
    total++; if (v_cyc !== 19) begin bad++; $display("FAIL ign_valid_cycle: got %0d want 19", v_cyc); end
    total++; if (out_class !== 2'd3) begin bad++; $display("FAIL ign_class: got %0d want 3", out_class); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_idle: got %b want 0", busy); end
  endtask

  task automatic test_abort();
    int n_valid = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    total++; if (fc_en !== 1'b1) begin bad++; $display("FAIL ab_beat7_en: got %b want 1", fc_en); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_busy: got %b want 0", busy); end
    total++; if (fc_en !== 1'b0) begin bad++; $display("FAIL ab_fc_en: got %b want 0", fc_en); end
    total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL ab_rd_en: got %b want 0", mem_rd_en); end
    for (int i = 0; i < 20; i++) begin
      fc_flag = 1'b1;
      if (out_valid) n_valid++;
      tick();
    end
    fc_flag = 1'b0;
    total++; if (n_valid !== 0) begin bad++; $display("FAIL ab_no_valid: got %0d want 0", n_valid); end
    // Fresh pass after the abort.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    fc_flag  = 1'b1;
    fc_class = CLASS_ABNORMAL;
    tick();
    fc_flag = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ab_rerun_valid: got %b want 1", out_valid); end
    total++; if (out_class !== CLASS_ABNORMAL) begin bad++; $display("FAIL ab_rerun_class: got %0d want 1", out_class); end
    tick();
    // Abort in WAIT with a same-cycle flag: no capture, no result.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    abort    = 1'b1;
    fc_flag  = 1'b1;
    fc_class = 2'd2;
    tick();
    abort   = 1'b0;
    fc_flag = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ab_wait_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_wait_busy: got %b want 0", busy); end
    total++; if (out_class !== CLASS_ABNORMAL) begin bad++; $display("FAIL ab_wait_class: got %0d want 1", out_class); end
  endtask

  task automatic test_back_to_back();
    int         nv = 0;
    int         vcyc [2];
    logic [1:0] vcls [2];
    vcyc[0] = 0;
    vcyc[1] = 0;
    vcls[0] = 2'd3;
    vcls[1] = 2'd3;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 40; c++) begin
      start    = (c == 20);
      fc_flag  = (c == 18) || (c == 38);
      fc_class = (c == 38) ? CLASS_ABNORMAL : CLASS_NORMAL;
      if (out_valid) begin
        if (nv < 2) begin
          vcyc[nv] = c;
          vcls[nv] = out_class;
        end
        nv++;
      end
      if (c == 19 || c == 20) begin
        total++; if (fc_en !== 1'b0) begin bad++; $display("FAIL b2b_gap c=%0d: got %b want 0", c, fc_en); end
      end
      if (c == 22) begin
        total++; if (fc_en !== 1'b1) begin bad++; $display("FAIL b2b_en2: got %b want 1", fc_en); end
      end
      tick();
    end
    start   = 1'b0;
    fc_flag = 1'b0;
    total++; if (nv !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", nv); end
    total++; if (vcyc[0] !== 19) begin bad++; $display("FAIL b2b_cyc0: got %0d want 19", vcyc[0]); end
    total++; if (vcyc[1] !== 39) begin bad++; $display("FAIL b2b_cyc1: got %0d want 39", vcyc[1]); end
    total++; if (vcls[0] !== CLASS_NORMAL) begin bad++; $display("FAIL b2b_cls0: got %0d want 0", vcls[0]); end
    total++; if (vcls[1] !== CLASS_ABNORMAL) begin bad++; $display("FAIL b2b_cls1: got %0d want 1", vcls[1]); end
  endtask

`ifdef FC_TIMEOUT_EN
  task automatic test_timeout();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    for (int c = 18; c <= 25; c++) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_busy c=%0d: got %b want 1", c, busy); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL to_early_err c=%0d: got %b want 0", c, err); end
      tick();
    end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle: got %b want 0", busy); end
    total++; if (fc_en !== 1'b0) begin bad++; $display("FAIL to_fc_en: got %b want 0", fc_en); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL to_valid: got %b want 0", out_valid); end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    fc_flag  = 1'b1;
    fc_class = CLASS_NORMAL;
    tick();
    fc_flag = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL to_next_valid: got %b want 1", out_valid); end
    total++; if (out_class !== CLASS_NORMAL) begin bad++; $display("FAIL to_next_class: got %0d want 0", out_class); end
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", err); end
  endtask
`else
  task automatic test_no_timeout();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    repeat (12) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL nt_busy: got %b want 1", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL nt_err: got %b want 0", err); end
    total++; if (fc_en !== 1'b1) begin bad++; $display("FAIL nt_fc_en: got %b want 1", fc_en); end
    fc_flag  = 1'b1;
    fc_class = 2'd2;
    tick();
    fc_flag = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL nt_valid: got %b want 1", out_valid); end
    total++; if (out_class !== 2'd2) begin bad++; $display("FAIL nt_class: got %0d want 2", out_class); end
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = {8'(128 + i), 8'(3 * i), 8'(-i), 8'(i)};
    end
    test_reset();
    test_full_pass();
    test_backpressure();
    test_start_ignored();
    test_abort();
    test_back_to_back();
`ifdef FC_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
